key_cmd_scheduler: RTL and testbench
====================================

KEY_CMD_SCHEDULER -- requirements
Module: key_cmd_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, 4, command FIFO depth (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  system clock (100 MHz).
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port key_down  input  512  per-scan-code pressed map from the keyboard decoder.
REQ-005 SHALL have port last_change  input  9  scan code of the most recent key event.
REQ-006 SHALL have port key_valid  input  1  one-cycle strobe marking a new key event.
REQ-007 SHALL have port play_pause  input  1  1 = playing, 0 = paused.
REQ-008 SHALL have port beat_tick  input  1  one-cycle strobe, high once per beat advance, clk domain.
REQ-009 SHALL have port volume  output  3  volume level, range 1..5.
REQ-010 SHALL have port octave  output  3  octave select, range 1..3.
REQ-011 SHALL have port speed  output  2  tempo select, range 0..2.
REQ-012 SHALL have port loop_width  output  3  loop window in beats, range 2..6.
REQ-013 SHALL have port reverse  output  1  playback direction, 1 = reverse.
REQ-014 SHALL have port cmd_pending  output  1  high while the FIFO is non-empty.
REQ-015 SHALL have port overflow  output  1  sticky flag, a command was dropped.

Function
REQ-016 SHALL treat a cycle as a key press when key_valid=1 and key_down[last_change]=1; releases and unmapped codes SHALL be ignored.
REQ-017 SHALL map scan codes to commands: 9'h03C VOL_UP, 9'h023 VOL_DN, 9'h044 OCT_UP, 9'h04B OCT_DN, 9'h02B SPD_UP, 9'h01B SPD_DN, 9'h01D LOOP_UP, 9'h031 LOOP_DN, 9'h02D REV_TOG, 9'h022 RESTORE.
REQ-018 SHALL write a mapped press into a DEPTH-entry FIFO at the clock edge ending the press cycle, preserving arrival order.
REQ-019 SHALL pop at most one command per cycle, when the FIFO is non-empty and (play_pause=0 or beat_tick=1).
REQ-020 SHALL update the affected output at the same clock edge as the pop, so a press while paused with an empty FIFO changes the output after the 2nd edge (1-cycle latency from the capture edge).
REQ-021 SHALL saturate: VOL_UP/DN at 5/1, OCT_UP/DN at 3/1, SPD_UP/DN at 2/0, LOOP_UP/DN at 6/2; a command at a limit SHALL still be consumed with no change.
REQ-022 SHALL invert reverse on REV_TOG.
REQ-023 SHALL load all defaults (volume 3, octave 2, speed 1, loop_width 4, reverse 0) and clear overflow on RESTORE.
REQ-024 SHALL implement a state machine IDLE (FIFO empty), WAIT (non-empty, playing, no beat_tick), APPLY (pop cycle): IDLE->APPLY on push while paused; IDLE->WAIT on push while playing; WAIT->APPLY on beat_tick or play_pause=0; APPLY->IDLE if the count becomes 0, else APPLY (paused) or WAIT (playing).
REQ-025 SHALL, on a push and a pop in the same cycle, keep the count unchanged and accept the push even when full.
REQ-026 SHALL, on a push to a full FIFO with no simultaneous pop, drop the command and set overflow; overflow SHALL clear only on RESTORE or reset.
REQ-027 SHALL wrap the read/write pointers modulo DEPTH, using a count of log2(DEPTH)+1 bits.
REQ-028 SHALL drive cmd_pending as a registered flag equal to (count != 0).
REQ-029 SHALL take a pop's effect into account when a RESTORE pop and an overflow-setting push coincide, leaving overflow=1.

Reset
REQ-030 SHALL, on rst=1 at any time including mid-WAIT, empty the FIFO, enter IDLE, and drive volume=3, octave=2, speed=1, loop_width=4, reverse=0, cmd_pending=0, overflow=0.
REQ-031 SHALL hold these values while rst=1 and ignore key events during reset.

Verification
REQ-032 SHALL cover: paused, press 9'h03C twice -> volume 3->4->5 on successive pops, a third press leaves 5, cmd_pending falls after the last pop.
REQ-033 SHALL cover: playing with beat_tick every 8 cycles, press 9'h044 -> octave stays 2 until the next beat_tick edge, then becomes 3.
REQ-034 SHALL cover: playing with no beat_tick, 5 presses of 9'h031 with DEPTH=4 -> overflow=1, then 4 beat_ticks -> loop_width 4->2 (saturates), FIFO empty.
REQ-035 SHALL cover: FIFO full plus simultaneous beat_tick and press of 9'h02D -> count stays 4, overflow stays 0, reverse toggles in order.
REQ-036 SHALL cover: rst asserted during WAIT with 3 queued commands -> all outputs return to defaults immediately and no queued command applies after release.
REQ-037 SHALL cover: press 9'h022 after changes -> defaults restored, overflow cleared.

Source files
------------

// File: rtl/key_cmd_scheduler.sv
// key_cmd_scheduler: turns mapped key presses into playback-control commands.
// Presses are queued in a DEPTH-entry FIFO and popped one per cycle while
// paused, or one per beat_tick while playing. Each pop updates one control
// output with saturation.
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   key_down     - per-scan-code pressed map
//   last_change  - scan code of most recent key event
//   key_valid    - one-cycle strobe for a new key event
//   play_pause   - 1 = playing, 0 = paused
//   beat_tick    - one-cycle strobe per beat
//   volume       - 1..5 (default 3)
//   octave       - 1..3 (default 2)
//   speed        - 0..2 (default 1)
//   loop_width   - 2..6 (default 4)
//   reverse      - playback direction
//   cmd_pending  - registered FIFO non-empty flag
//   overflow     - sticky dropped-command flag, cleared by RESTORE or reset
module key_cmd_scheduler #(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] key_down,
  input  logic [8:0]   last_change,
  input  logic         key_valid,
  input  logic         play_pause,
  input  logic         beat_tick,
  output logic [2:0]   volume,
  output logic [2:0]   octave,
  output logic [1:0]   speed,
  output logic [2:0]   loop_width,
  output logic         reverse,
  output logic         cmd_pending,
  output logic         overflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  typedef enum logic [3:0] {
    CmdVolUp, CmdVolDn, CmdOctUp, CmdOctDn, CmdSpdUp,
    CmdSpdDn, CmdLoopUp, CmdLoopDn, CmdRevTog, CmdRestore
  } cmd_e;

  typedef enum logic [1:0] {StIdle, StWait, StApply} state_e;

  state_e        state_q, state_d;
  cmd_e          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    volume_q, volume_d, octave_q, octave_d, loop_q, loop_d;
  logic [1:0]    speed_q, speed_d;
  logic          reverse_q, reverse_d, pending_q, overflow_q, overflow_d;

  cmd_e cmd_code, head;
  logic cmd_valid, push, pop, full, accept, drop;

  // Scan-code decode
  always_comb begin
    cmd_valid = 1'b1;
    cmd_code  = CmdVolUp;
    unique case (last_change)
      9'h03C:  cmd_code = CmdVolUp;
      9'h023:  cmd_code = CmdVolDn;
      9'h044:  cmd_code = CmdOctUp;
      9'h04B:  cmd_code = CmdOctDn;
      9'h02B:  cmd_code = CmdSpdUp;
      9'h01B:  cmd_code = CmdSpdDn;
      9'h01D:  cmd_code = CmdLoopUp;
      9'h031:  cmd_code = CmdLoopDn;
      9'h02D:  cmd_code = CmdRevTog;
      9'h022:  cmd_code = CmdRestore;
      default: cmd_valid = 1'b0;
    endcase
  end

  assign push   = key_valid && key_down[last_change] && cmd_valid;
  assign full   = (count_q == FullCnt);
  assign pop    = (count_q != '0) && (!play_pause || beat_tick);
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;
  assign head   = mem_q[rd_ptr_q];

  // FIFO bookkeeping; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (accept && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !accept) begin
      count_d = count_q - CW'(1);
    end
  end

  // Command application on pop
  always_comb begin
    volume_d   = volume_q;
    octave_d   = octave_q;
    speed_d    = speed_q;
    loop_d     = loop_q;
    reverse_d  = reverse_q;
    overflow_d = overflow_q;
    if (pop) begin
      unique case (head)
        CmdVolUp:  if (volume_q < 3'd5) volume_d = volume_q + 3'd1;
        CmdVolDn:  if (volume_q > 3'd1) volume_d = volume_q - 3'd1;
        CmdOctUp:  if (octave_q < 3'd3) octave_d = octave_q + 3'd1;
        CmdOctDn:  if (octave_q > 3'd1) octave_d = octave_q - 3'd1;
        CmdSpdUp:  if (speed_q < 2'd2) speed_d = speed_q + 2'd1;
        CmdSpdDn:  if (speed_q > 2'd0) speed_d = speed_q - 2'd1;
        CmdLoopUp: if (loop_q < 3'd6) loop_d = loop_q + 3'd1;
        CmdLoopDn: if (loop_q > 3'd2) loop_d = loop_q - 3'd1;
        CmdRevTog: reverse_d = ~reverse_q;
        CmdRestore: begin
          volume_d   = 3'd3;
          octave_d   = 3'd2;
          speed_d    = 2'd1;
          loop_d     = 3'd4;
          reverse_d  = 1'b0;
          overflow_d = 1'b0;
        end
        default: ;
      endcase
    end
    // Applied after the pop so a drop is never masked by a RESTORE
    if (drop) overflow_d = 1'b1;
  end

  // Scheduler state: idle when empty, apply while paused, wait while playing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (push) state_d = play_pause ? StWait : StApply;
      end
      StWait, StApply: begin
        if (count_d == '0) begin
          state_d = StIdle;
        end else begin
          state_d = play_pause ? StWait : StApply;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      volume_q   <= 3'd3;
      octave_q   <= 3'd2;
      speed_q    <= 2'd1;
      loop_q     <= 3'd4;
      reverse_q  <= 1'b0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      volume_q   <= volume_d;
      octave_q   <= octave_d;
      speed_q    <= speed_d;
      loop_q     <= loop_d;
      reverse_q  <= reverse_d;
      pending_q  <= (count_d != '0);
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; entries are only read once written
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= cmd_code;
  end

  assign volume      = volume_q;
  assign octave      = octave_q;
  assign speed       = speed_q;
  assign loop_width  = loop_q;
  assign reverse     = reverse_q;
  assign cmd_pending = pending_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
module tb_key_cmd_scheduler;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] key_down = '0;
  logic [8:0]   last_change = '0;
  logic         key_valid = 1'b0;
  logic         play_pause = 1'b0;
  logic         beat_tick = 1'b0;
  logic [2:0]   volume, octave, loop_width;
  logic [1:0]   speed;
  logic         reverse, cmd_pending, overflow;

  key_cmd_scheduler #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .key_down(key_down), .last_change(last_change),
    .key_valid(key_valid), .play_pause(play_pause), .beat_tick(beat_tick),
    .volume(volume), .octave(octave), .speed(speed), .loop_width(loop_width),
    .reverse(reverse), .cmd_pending(cmd_pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int mq[$];
  int m_vol = 3, m_oct = 2, m_spd = 1, m_loop = 4, m_rev = 0, m_ov = 0;

  function automatic int code_of(logic [8:0] sc);
    case (sc)
      9'h03C: return 0;  9'h023: return 1;  9'h044: return 2;  9'h04B: return 3;
      9'h02B: return 4;  9'h01B: return 5;  9'h01D: return 6;  9'h031: return 7;
      9'h02D: return 8;  9'h022: return 9;
      default: return -1;
    endcase
  endfunction

  task automatic model_defaults();
    m_vol = 3; m_oct = 2; m_spd = 1; m_loop = 4; m_rev = 0;
  endtask

  task automatic model_apply(int c);
    case (c)
      0: if (m_vol < 5) m_vol++;
      1: if (m_vol > 1) m_vol--;
      2: if (m_oct < 3) m_oct++;
      3: if (m_oct > 1) m_oct--;
      4: if (m_spd < 2) m_spd++;
      5: if (m_spd > 0) m_spd--;
      6: if (m_loop < 6) m_loop++;
      7: if (m_loop > 2) m_loop--;
      8: m_rev = 1 - m_rev;
      9: begin model_defaults(); m_ov = 0; end
      default: ;
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      model_defaults();
      m_ov = 0;
    end else begin
      int idx;
      if (mq.size() != 0 && (!play_pause || beat_tick)) model_apply(mq.pop_front());
      idx = code_of(last_change);
      if (key_valid && key_down[last_change] && idx >= 0) begin
        if (mq.size() < DEPTH) mq.push_back(idx);
        else m_ov = 1;
      end
    end
  end

  // Compare process: outputs are stable mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("volume", int'(volume), m_vol);
      check("octave", int'(octave), m_oct);
      check("speed", int'(speed), m_spd);
      check("loop_width", int'(loop_width), m_loop);
      check("reverse", int'(reverse), m_rev);
      check("cmd_pending", int'(cmd_pending), int'(mq.size() != 0));
      check("overflow", int'(overflow), m_ov);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(logic [8:0] sc);
    last_change = sc;
    key_down = '0;
    key_down[sc] = 1'b1;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    key_down = '0;
  endtask

  task automatic do_reset();
    key_valid = 1'b0;
    beat_tick = 1'b0;
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
  endtask

  logic [8:0] codes [10] = '{9'h03C, 9'h023, 9'h044, 9'h04B, 9'h02B,
                             9'h01B, 9'h01D, 9'h031, 9'h02D, 9'h022};

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("rst_volume", int'(volume), 3);
    check("rst_octave", int'(octave), 2);
    check("rst_speed", int'(speed), 1);
    check("rst_loop", int'(loop_width), 4);
    check("rst_pending", int'(cmd_pending), 0);

    // Paused volume-up presses, saturating at 5
    play_pause = 1'b0;
    press(9'h03C);
    press(9'h03C);
    check("vol_first_pop", int'(volume), 4);
    step();
    check("vol_second_pop", int'(volume), 5);
    check("vol_pending_low", int'(cmd_pending), 0);
    press(9'h03C);
    check("vol_third_queued", int'(cmd_pending), 1);
    step();
    check("vol_saturated", int'(volume), 5);

    // Playing: octave waits for the beat
    do_reset();
    play_pause = 1'b1;
    press(9'h044);
    for (int i = 0; i < 7; i++) begin
      check("oct_waiting", int'(octave), 2);
      step();
    end
    beat_tick = 1'b1;
    step();
    beat_tick = 1'b0;
    check("oct_on_beat", int'(octave), 3);
    check("oct_pending_low", int'(cmd_pending), 0);

    // Overflow with five loop-down presses, then drain on beats
    do_reset();
    play_pause = 1'b1;
    for (int i = 0; i < 5; i++) press(9'h031);
    check("ovf_set", int'(overflow), 1);
    for (int i = 0; i < 4; i++) begin
      beat_tick = 1'b1;
      step();
      beat_tick = 1'b0;
      step();
    end
    check("loop_saturated", int'(loop_width), 2);
    check("loop_fifo_empty", int'(cmd_pending), 0);
    check("ovf_sticky", int'(overflow), 1);

    // Full FIFO with simultaneous beat and press
    do_reset();
    play_pause = 1'b1;
    for (int i = 0; i < 4; i++) press(9'h02D);
    beat_tick = 1'b1;
    press(9'h02D);
    beat_tick = 1'b0;
    check("full_rev_first", int'(reverse), 1);
    check("full_no_ovf", int'(overflow), 0);
    check("full_pending", int'(cmd_pending), 1);
    play_pause = 1'b0;
    steps(6);
    check("full_rev_final", int'(reverse), 1);
    check("full_drained", int'(cmd_pending), 0);

    // Reset mid-wait discards queued commands
    do_reset();
    play_pause = 1'b1;
    for (int i = 0; i < 3; i++) press(9'h03C);
    check("wait_pending", int'(cmd_pending), 1);
    rst = 1'b1;
    #1;
    check("midrst_pending", int'(cmd_pending), 0);
    check("midrst_volume", int'(volume), 3);
    step();
    rst = 1'b0;
    play_pause = 1'b0;
    steps(5);
    check("postrst_volume", int'(volume), 3);

    // Restore after changes and an overflow
    do_reset();
    play_pause = 1'b1;
    for (int i = 0; i < 5; i++) press(9'h03C);
    play_pause = 1'b0;
    steps(5);
    check("pre_restore_vol", int'(volume), 5);
    check("pre_restore_ovf", int'(overflow), 1);
    press(9'h02B);
    press(9'h022);
    step();
    check("restore_vol", int'(volume), 3);
    check("restore_speed", int'(speed), 1);
    check("restore_ovf", int'(overflow), 0);

    // Randomised traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic [8:0] sc;
      sc = ($urandom_range(0, 9) < 8) ? codes[$urandom_range(0, 9)] : 9'($urandom());
      key_down = {16{$urandom()}};
      key_down[sc] = ($urandom_range(0, 3) != 0);
      last_change = sc;
      key_valid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) play_pause = ~play_pause;
      beat_tick = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    key_valid = 1'b0;
    beat_tick = 1'b0;
    play_pause = 1'b0;
    steps(8);
    check("final_drained", int'(cmd_pending), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
